// File: rtl/alu_req_sequencer.sv
// rtl/alu_req_sequencer.sv - two-requester round-robin front end for the hierarchical ALU
module alu_req_sequencer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [3:0]           fun0,
  input  logic [3:0]           fun1,
  input  logic [IN_WIDTH-1:0]  a0,
  input  logic [IN_WIDTH-1:0]  b0,
  input  logic [IN_WIDTH-1:0]  a1,
  input  logic [IN_WIDTH-1:0]  b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [IN_WIDTH-1:0]  ALU_A,
  output logic [IN_WIDTH-1:0]  ALU_B,
  output logic [1:0]           ALU_FUN,
  output logic                 Arith_Enable,
  output logic                 Logic_Enable,
  output logic                 CMP_Enable,
  output logic                 SHIFT_Enable,
  input  logic [OUT_WIDTH-1:0] ALU_OUT,
  input  logic                 ALU_Flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [OUT_WIDTH-1:0] rsp_data,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_ptr;      // id granted last; reset to 1 so req0 wins the first tie
  logic                  r_id;       // owner of the operation in flight
  logic [1:0]            r_unit;
  logic [IN_WIDTH-1:0]   r_a;
  logic [IN_WIDTH-1:0]   r_b;
  logic [1:0]            r_fun;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_err;
  logic                  w_any;
  logic                  w_win;      // 1 when requester 1 wins this arbitration
  logic                  w_start;

  assign w_any   = req0 | req1;
  assign w_win   = req1 & (~req0 | ~r_ptr);
  assign w_start = (r_state == IDLE) && w_any;

  // Operand registers feed the ALU directly, so they naturally hold outside ISSUE.
  assign ALU_A    = r_a;
  assign ALU_B    = r_b;
  assign ALU_FUN  = r_fun;
  assign rsp_id   = r_id;
  assign rsp_data = r_data;
  assign rsp_err  = r_err;

  // State register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode plus grant, unit-enable and response-valid outputs
  always_comb begin
    w_next       = r_state;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    Arith_Enable = 1'b0;
    Logic_Enable = 1'b0;
    CMP_Enable   = 1'b0;
    SHIFT_Enable = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        gnt0   = ~r_id;
        gnt1   = r_id;
        case (r_unit)
          2'b00:   Arith_Enable = 1'b1;
          2'b01:   Logic_Enable = 1'b1;
          2'b10:   CMP_Enable   = 1'b1;
          default: SHIFT_Enable = 1'b1;
        endcase
        w_next = WAIT;
      end
      WAIT: begin
        w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the winner's command, capture the unit result, advance the round-robin pointer
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_ptr  <= 1'b1;
      r_id   <= 1'b0;
      r_unit <= 2'b00;
      r_a    <= '0;
      r_b    <= '0;
      r_fun  <= 2'b00;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_id   <= w_win;
        r_unit <= w_win ? fun1[3:2] : fun0[3:2];
        r_fun  <= w_win ? fun1[1:0] : fun0[1:0];
        r_a    <= w_win ? a1 : a0;
        r_b    <= w_win ? b1 : b0;
      end
      if (r_state == WAIT) begin
        r_data <= ALU_OUT;
        r_err  <= ~ALU_Flag;
      end
      if ((r_state == RESP) && rsp_ready) begin
        r_ptr <= r_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb/tb_alu_req_sequencer.sv - directed self-checking bench for alu_req_sequencer
module tb_alu_req_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        req0, req1;
  logic [3:0]  fun0, fun1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic [7:0]  ALU_A, ALU_B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] ALU_OUT;
  logic        ALU_Flag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic        stub_err;
  logic [3:0]  en;

  int n_pass, n_total, n_fail;
  int w;

  alu_req_sequencer #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .clk(clk), .RST(RST),
    .req0(req0), .req1(req1), .fun0(fun0), .fun1(fun1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .ALU_OUT(ALU_OUT), .ALU_Flag(ALU_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  assign en = {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable};

  // Stub of the four ALU units: one-cycle registered result and valid flag
  function automatic logic [15:0] unit_f(input logic [3:0] e, input logic [1:0] f,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa, xb;
    xa = {8'h00, a};
    xb = {8'h00, b};
    case (e)
      4'b1000: case (f)
                 2'd0: return xa + xb;
                 2'd1: return xa - xb;
                 2'd2: return xa * xb;
                 default: return (b == 8'h00) ? 16'h0000 : xa / xb;
               endcase
      4'b0100: case (f)
                 2'd0: return xa & xb;
                 2'd1: return xa | xb;
                 2'd2: return {8'h00, ~(a & b)};
                 default: return {8'h00, ~(a | b)};
               endcase
      4'b0010: case (f)
                 2'd1: return {15'h0, a == b};
                 2'd2: return {15'h0, a > b};
                 2'd3: return {15'h0, a < b};
                 default: return 16'h0000;
               endcase
      4'b0001: case (f)
                 2'd0: return xa >> 1;
                 2'd1: return xa << 1;
                 2'd2: return xb >> 1;
                 default: return xb << 1;
               endcase
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (en != 4'b0000) begin
      ALU_OUT  <= unit_f(en, ALU_FUN, ALU_A, ALU_B);
      ALU_Flag <= ~stub_err;
    end else begin
      ALU_OUT  <= 16'h0000;
      ALU_Flag <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete operation from requester id with rsp_ready high; returns at the RESP sample point
  task automatic run_op(input logic id, input logic [3:0] fn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] ed, input logic ee,
                        output int waited);
    if (id) begin req1 = 1'b1; fun1 = fn; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; fun0 = fn; a0 = a; b0 = b; end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(gnt0 | gnt1) && waited < 16);
    chk("op_gnt", {gnt1, gnt0}, id ? 2'b10 : 2'b01);
    chk("op_enable", en, 4'b1000 >> fn[3:2]);
    chk("op_alu_a", ALU_A, a);
    chk("op_alu_b", ALU_B, b);
    chk("op_alu_fun", ALU_FUN, fn[1:0]);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    chk("op_enable_wait", en, 4'b0000);
    chk("op_valid_wait", rsp_valid, 1'b0);
    @(negedge clk);
    chk("op_rsp_valid", rsp_valid, 1'b1);
    chk("op_rsp_id", rsp_id, id);
    chk("op_rsp_data", rsp_data, ed);
    chk("op_rsp_err", rsp_err, ee);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    RST = 1'b0; req0 = 1'b0; req1 = 1'b0;
    fun0 = 4'h0; fun1 = 4'h0; a0 = 8'h0; b0 = 8'h0; a1 = 8'h0; b1 = 8'h0;
    rsp_ready = 1'b1; stub_err = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_enable", en, 4'b0000);
    chk("rst_alu_a", ALU_A, 8'h00);
    chk("rst_alu_b", ALU_B, 8'h00);
    chk("rst_alu_fun", ALU_FUN, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_err", rsp_err, 1'b0);

    RST = 1'b1;
    @(negedge clk);

    // Tie: both held high; req0 wins first after reset, then alternation
    fun0 = 4'b0000; a0 = 8'h02; b0 = 8'h03;
    fun1 = 4'b0101; a1 = 8'hF0; b1 = 8'h0F;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(gnt0 | gnt1) && w < 16);
      chk("tie_gnt", {gnt1, gnt0}, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("tie_gap", w, (i == 0) ? 1 : 2);
      @(negedge clk);
      @(negedge clk);
      chk("tie_rsp_valid", rsp_valid, 1'b1);
      chk("tie_rsp_id", rsp_id, (i % 2 == 1) ? 1 : 0);
      chk("tie_rsp_data", rsp_data, (i % 2 == 1) ? 16'h00FF : 16'h0005);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Single compare-equal from req0: grant one cycle after the sampling edge
    run_op(1'b0, 4'b1001, 8'h3C, 8'h3C, 16'h0001, 1'b0, w);
    chk("cmp_latency", w, 1);
    @(negedge clk);

    // Backpressure: req1 wins (last grant was 0), req0 waits behind it
    rsp_ready = 1'b0;
    fun0 = 4'b0010; a0 = 8'h12; b0 = 8'h10; req0 = 1'b1;
    run_op(1'b1, 4'b0001, 8'h10, 8'h03, 16'h000D, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_id", rsp_id, 1'b1);
      chk("bp_data", rsp_data, 16'h000D);
      chk("bp_no_gnt", {gnt1, gnt0}, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_gnt", {gnt1, gnt0}, 2'b00);
    chk("bp_idle_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("bp_next_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_id", rsp_id, 1'b0);
    chk("bp_next_data", rsp_data, 16'h0120);
    @(negedge clk);

    // Greater-than false from req1
    run_op(1'b1, 4'b1010, 8'h01, 8'hF0, 16'h0000, 1'b0, w);
    @(negedge clk);

    // Enable routing, one op per unit, then a flag-low unit
    run_op(1'b0, 4'b0000, 8'h7F, 8'h01, 16'h0080, 1'b0, w);
    @(negedge clk);
    run_op(1'b0, 4'b0100, 8'h3C, 8'h0F, 16'h000C, 1'b0, w);
    @(negedge clk);
    run_op(1'b0, 4'b1011, 8'h01, 8'h02, 16'h0001, 1'b0, w);
    @(negedge clk);
    run_op(1'b0, 4'b1101, 8'h81, 8'h00, 16'h0102, 1'b0, w);
    @(negedge clk);
    stub_err = 1'b1;
    run_op(1'b0, 4'b0000, 8'h01, 8'h01, 16'h0002, 1'b1, w);
    stub_err = 1'b0;
    @(negedge clk);

    // Reset asserted during WAIT
    req0 = 1'b1; fun0 = 4'b0000; a0 = 8'h04; b0 = 8'h05;
    @(negedge clk);
    chk("rw_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    @(negedge clk);
    #2 RST = 1'b0;
    #1;
    chk("rw_gnt_clr", {gnt1, gnt0}, 2'b00);
    chk("rw_enable_clr", en, 4'b0000);
    chk("rw_alu_a_clr", ALU_A, 8'h00);
    chk("rw_alu_b_clr", ALU_B, 8'h00);
    chk("rw_valid_clr", rsp_valid, 1'b0);
    chk("rw_data_clr", rsp_data, 16'h0000);
    chk("rw_err_clr", rsp_err, 1'b0);
    @(negedge clk);
    RST = 1'b1;
    req1 = 1'b1; fun1 = 4'b0011; a1 = 8'h20; b1 = 8'h04;
    @(negedge clk);
    chk("rw_gnt1", {gnt1, gnt0}, 2'b10);
    chk("rw_no_stale", rsp_valid, 1'b0);
    req1 = 1'b0;
    @(negedge clk);
    chk("rw_wait_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rw_rsp_valid", rsp_valid, 1'b1);
    chk("rw_rsp_id", rsp_id, 1'b1);
    chk("rw_rsp_data", rsp_data, 16'h0008);
    @(negedge clk);
    chk("rw_done_valid", rsp_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
